// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding sobel_blackBorder; emits one window per pixel and flushes border windows at frame end.
// Optional SOBEL_WIN_SOF_RESYNC_EN: an accepted pixel with in_sof=1 restarts framing at (0,0).
module sobel_window_gen #(
    parameter int MAX_ROW = 480,
    parameter int MAX_COL = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pixel_in,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    output logic [9:0]  out_row,
    output logic [9:0]  out_col,
    output logic [63:0] out_pixels,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(MAX_COL);
    localparam logic [9:0] LAST_ROW = 10'(MAX_ROW - 1);
    localparam logic [9:0] LAST_COL = 10'(MAX_COL - 1);

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    state_t state_reg, state_next;

    logic [9:0] ir_reg, ic_reg, ir_next, ic_next;
    logic [9:0] cr_reg, cc_reg, cr_next, cc_next;
    logic [9:0] eff_ir, eff_ic;

    logic accept;
    logic sof_hit;
    logic slot_free;
    logic load;
    logic last_in;
    logic last_ctr;
    logic border;

    logic [7:0] lb0 [0:MAX_COL-1];
    logic [7:0] lb1 [0:MAX_COL-1];
    logic [7:0] lb0_rd_reg, lb1_rd_reg;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    // Per row: [1] is the window's left column, [0] the centre column.
    logic [2:0][1:0][7:0] hist_reg, hist_next;
    logic [2:0][7:0]      col_new;
    logic [63:0]          pix_pack;

    logic        out_valid_reg;
    logic [9:0]  out_row_reg, out_col_reg;
    logic [63:0] out_pixels_reg;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = !reset && (state_reg != FLUSH) && slot_free;
    assign accept    = in_valid && in_ready;

`ifdef SOBEL_WIN_SOF_RESYNC_EN
    assign sof_hit = accept && in_sof;
`else
    logic sof_unused;
    assign sof_unused = in_sof;
    assign sof_hit    = 1'b0;
`endif

    assign eff_ir   = sof_hit ? 10'd0 : ir_reg;
    assign eff_ic   = sof_hit ? 10'd0 : ic_reg;
    assign last_in  = (eff_ir == LAST_ROW) && (eff_ic == LAST_COL);
    assign last_ctr = (cr_reg == LAST_ROW) && (cc_reg == LAST_COL);
    assign border   = (cr_reg == 10'd0) || (cr_reg == LAST_ROW) ||
                      (cc_reg == 10'd0) || (cc_reg == LAST_COL);

    // Input position counters
    always_comb begin
        ir_next = ir_reg;
        ic_next = ic_reg;
        if (accept) begin
            if (eff_ic == LAST_COL) begin
                ic_next = 10'd0;
                ir_next = (eff_ir == LAST_ROW) ? 10'd0 : eff_ir + 10'd1;
            end else begin
                ic_next = eff_ic + 10'd1;
                ir_next = eff_ir;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            FILL: begin
                if (accept && (eff_ir == 10'd1) && (eff_ic == 10'd0)) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (sof_hit) begin
                        state_next = FILL;
                    end else begin
                        load = 1'b1;
                        if (last_in) begin
                            state_next = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load = 1'b1;
                    if (last_ctr) begin
                        state_next = FILL;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Centre counters advance once per emitted window and wrap to (0,0) after the flush.
    always_comb begin
        cr_next = cr_reg;
        cc_next = cc_reg;
        if (sof_hit) begin
            cr_next = 10'd0;
            cc_next = 10'd0;
        end else if (load) begin
            if (cc_reg == LAST_COL) begin
                cc_next = 10'd0;
                cr_next = (cr_reg == LAST_ROW) ? 10'd0 : cr_reg + 10'd1;
            end else begin
                cc_next = cc_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FILL;
            ir_reg    <= 10'd0;
            ic_reg    <= 10'd0;
            cr_reg    <= 10'd0;
            cc_reg    <= 10'd0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            ic_reg    <= ic_next;
            cr_reg    <= cr_next;
            cc_reg    <= cc_next;
        end
    end

    // Read port prefetches the column of the next accept, so its data is ready when that pixel arrives.
    assign rd_addr = ic_next[AW-1:0];
    assign wr_addr = eff_ic[AW-1:0];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[wr_addr] <= pixel_in;
            lb1[wr_addr] <= lb0_rd_reg;
        end
        lb0_rd_reg <= lb0[rd_addr];
        lb1_rd_reg <= lb1[rd_addr];
    end

    assign col_new[0] = lb1_rd_reg;
    assign col_new[1] = lb0_rd_reg;
    assign col_new[2] = pixel_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            assign hist_next[gi] = {hist_reg[gi][0], col_new[gi]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (accept) begin
            hist_reg <= hist_next;
        end
    end

    assign pix_pack = {hist_reg[0][1], hist_reg[0][0], col_new[0],
                       hist_reg[1][1],                 col_new[1],
                       hist_reg[2][1], hist_reg[2][0], col_new[2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_row_reg    <= 10'd0;
            out_col_reg    <= 10'd0;
            out_pixels_reg <= 64'h0;
        end else if (load) begin
            out_valid_reg  <= 1'b1;
            out_row_reg    <= cr_reg;
            out_col_reg    <= cc_reg;
            out_pixels_reg <= border ? 64'h0 : pix_pack;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_row    = out_row_reg;
    assign out_col    = out_col_reg;
    assign out_pixels = out_pixels_reg;

endmodule
